// File: rtl/maze_pkg.sv
// maze_pkg: maze dimensions, cell encoding, writer states, reset map and cell indexing
package maze_pkg;
  localparam int MAZE_ROWS = 8;
  localparam int MAZE_COLS = 8;
  localparam logic CELL_OPEN = 1'b1;
  localparam logic CELL_WALL = 1'b0;
  localparam logic [63:0] MAZE_RESET_MAP = 64'h00_78_48_7E_42_42_7E_00;
  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;
  function automatic logic [5:0] cell_index(input logic [2:0] row, input logic [2:0] col);
    return {row, col};
  endfunction
endpackage

// File: rtl/maze_map_lookup.sv
// maze_map_lookup: registered, range-checked cell read of a 64-bit map (cell 0,0 at bit 63)
module maze_map_lookup
  import maze_pkg::*;
#(
  parameter int ROWS = MAZE_ROWS,
  parameter int COLS = MAZE_COLS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] map,
  input  logic [7:0]  row,
  input  logic [7:0]  col,
  output logic        open
);
  // out-of-range coordinates read as wall rather than wrapping
  always_ff @(posedge clk)
    if (reset) open <= CELL_WALL;
    else open <= (row < 8'(ROWS) && col < 8'(COLS)) ? map[6'd63 - cell_index(row[2:0], col[2:0])] : CELL_WALL;
endmodule

// File: rtl/maze_map_writer.sv
// maze_map_writer: double-buffered row loader and cell editor for the 8x8 maze map (option MAZE_BORDER_LOCK_EN)
module maze_map_writer
  import maze_pkg::*;
#(
  parameter int ROWS = MAZE_ROWS,
  parameter int COLS = MAZE_COLS,
  parameter logic [63:0] RESET_MAP = MAZE_RESET_MAP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic        edit_valid,
  input  logic [2:0]  edit_row,
  input  logic [2:0]  edit_col,
  input  logic        edit_open,
  output logic        edit_ready,
  input  logic [7:0]  rd_row,
  input  logic [7:0]  rd_col,
  output logic        rd_open,
  output logic        busy,
  output logic        load_done,
  output logic [63:0] map_bits
);
  state_t state, nxt;
  logic [2:0] cnt;
  logic [63:0] shadow, active;
  logic xfer;
  logic [7:0] row_byte;
  logic cell_val;
`ifdef MAZE_BORDER_LOCK_EN
  assign row_byte = (cnt == 3'd0 || cnt == 3'(ROWS - 1)) ? 8'h00 : byte_data & 8'h7E;
  assign cell_val = (edit_row == 3'd0 || edit_row == 3'(ROWS - 1) || edit_col == 3'd0 || edit_col == 3'(COLS - 1)) ? CELL_WALL : edit_open;
`else
  assign row_byte = byte_data;
  assign cell_val = edit_open;
`endif
  // handshakes and status follow the state; everything is held low while reset is asserted
  always_comb begin
    byte_ready = !reset && state == LOAD;
    edit_ready = !reset && state == IDLE;
    busy = !reset && state != IDLE;
    load_done = !reset && state == COMMIT;
    xfer = byte_valid && byte_ready;
    nxt = state == IDLE ? (load_start ? LOAD : IDLE) :
          state == LOAD ? ((xfer && !load_start && cnt == 3'(ROWS - 1)) ? COMMIT : LOAD) : IDLE;
  end
  // state register
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= nxt;
  // row counter and shadow fill, commit into the active map, single-cell edits in IDLE
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= 3'd0;
      shadow <= 64'd0;
      active <= RESET_MAP;
    end else begin
      if (load_start && state != COMMIT) cnt <= 3'd0;
      else if (xfer) cnt <= cnt + 3'd1;
      if (xfer && !load_start) shadow[8 * (3'(ROWS - 1) - cnt) +: 8] <= row_byte;
      if (state == COMMIT) active <= shadow;
      else if (edit_valid && edit_ready) active[6'd63 - cell_index(edit_row, edit_col)] <= cell_val;
    end
  assign map_bits = active;
  maze_map_lookup #(.ROWS(ROWS), .COLS(COLS)) u_lookup (
    .clk(clk),
    .reset(reset),
    .map(active),
    .row(rd_row),
    .col(rd_col),
    .open(rd_open)
  );
endmodule

// File: tb/tb_maze_map_writer.sv
// tb_maze_map_writer: directed table and sequences plus randomized traffic against a cell-array model
module tb_maze_map_writer;
  logic clk = 1'b0;
  logic reset, load_start, byte_valid, edit_valid, edit_open;
  logic [7:0] byte_data, rd_row, rd_col;
  logic [2:0] edit_row, edit_col;
  logic byte_ready, edit_ready, rd_open, busy, load_done;
  logic [63:0] map_bits;
  int checks = 0;
  int failures = 0;
`ifdef MAZE_BORDER_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif
  localparam logic [63:0] RMAP = 64'h0078487E42427E00;
  typedef struct {
    logic [7:0] r;
    logic [7:0] c;
    logic exp;
  } rd_vec_t;
  rd_vec_t tbl[10];
  bit mm[8][8];
  bit m_loading, m_commit, m_rd;
  logic [7:0] q[$];
  logic [63:0] pre, e1, e2;
  always #5 clk = ~clk;
  maze_map_writer dut (
    .clk(clk), .reset(reset), .load_start(load_start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .edit_valid(edit_valid),
    .edit_row(edit_row), .edit_col(edit_col), .edit_open(edit_open),
    .edit_ready(edit_ready), .rd_row(rd_row), .rd_col(rd_col), .rd_open(rd_open),
    .busy(busy), .load_done(load_done), .map_bits(map_bits)
  );
  function automatic bit border(int r, int c);
    return r == 0 || r == 7 || c == 0 || c == 7;
  endfunction
  function automatic logic [63:0] mflat();
    logic [63:0] f;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) f[63 - (r * 8 + c)] = mm[r][c];
    return f;
  endfunction
  task automatic mreset();
    logic [63:0] rm;
    rm = RMAP;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) mm[r][c] = rm[63 - (r * 8 + c)];
    m_loading = 0;
    m_commit = 0;
    m_rd = 0;
    q.delete();
  endtask
  task automatic mstep();
    logic [7:0] b;
    if (reset) mreset();
    else begin
      m_rd = 0;
      if (rd_row < 8 && rd_col < 8) m_rd = mm[rd_row][rd_col];
      if (m_commit) begin
        for (int r = 0; r < 8; r++) begin
          b = q[r];
          for (int c = 0; c < 8; c++) mm[r][c] = (LOCK && border(r, c)) ? 1'b0 : b[7 - c];
        end
        m_commit = 0;
        q.delete();
      end else if (m_loading) begin
        if (load_start) q.delete();
        else if (byte_valid) begin
          q.push_back(byte_data);
          if (q.size() == 8) begin
            m_loading = 0;
            m_commit = 1;
          end
        end
      end else begin
        if (edit_valid) mm[edit_row][edit_col] = (LOCK && border(edit_row, edit_col)) ? 1'b0 : edit_open;
        if (load_start) begin
          m_loading = 1;
          q.delete();
        end
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    mstep();
    #1;
  endtask
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic idle_inputs();
    load_start = 0;
    byte_valid = 0;
    byte_data = 0;
    edit_valid = 0;
    edit_row = 0;
    edit_col = 0;
    edit_open = 0;
  endtask
  task automatic send_byte(input logic [7:0] d);
    byte_valid = 1;
    byte_data = d;
    tick();
    byte_valid = 0;
  endtask
  initial begin
    tbl[0] = '{8'd1, 8'd1, 1'b1};
    tbl[1] = '{8'd0, 8'd0, 1'b0};
    tbl[2] = '{8'd1, 8'd4, 1'b1};
    tbl[3] = '{8'd1, 8'd5, 1'b0};
    tbl[4] = '{8'd2, 8'd1, 1'b1};
    tbl[5] = '{8'd3, 8'd6, 1'b1};
    tbl[6] = '{8'd4, 8'd1, 1'b1};
    tbl[7] = '{8'd8, 8'd0, 1'b0};
    tbl[8] = '{8'd0, 8'd200, 1'b0};
    tbl[9] = '{8'd255, 8'd255, 1'b0};
    idle_inputs();
    rd_row = 0;
    rd_col = 0;
    reset = 1;
    tick();
    tick();
    chk("reset_edit_ready", edit_ready, 0);
    chk("reset_rd_open", rd_open, 0);
    chk("reset_map", map_bits, RMAP);
    reset = 0;
    #1;
    chk("idle_edit_ready", edit_ready, 1);
    chk("idle_byte_ready", byte_ready, 0);
    chk("idle_busy", busy, 0);
    chk("idle_load_done", load_done, 0);
    for (int i = 0; i < 10; i++) begin
      rd_row = tbl[i].r;
      rd_col = tbl[i].c;
      tick();
      chk($sformatf("rd_tbl%0d", i), rd_open, tbl[i].exp);
    end
    e1 = LOCK ? RMAP : RMAP | (64'd1 << 39);
    edit_valid = 1;
    edit_row = 3;
    edit_col = 0;
    edit_open = 1;
    #1;
    chk("edit_ready_pulse", edit_ready, 1);
    tick();
    edit_valid = 0;
    chk("edit_border_map", map_bits, e1);
    e2 = e1 & ~(64'd1 << 54);
    rd_row = 1;
    rd_col = 1;
    edit_valid = 1;
    edit_row = 1;
    edit_col = 1;
    edit_open = 0;
    tick();
    edit_valid = 0;
    chk("edit_read_pre_value", rd_open, 1);
    chk("edit_wall_map", map_bits, e2);
    rd_row = 3;
    rd_col = 0;
    tick();
    chk("edit_readback", rd_open, !LOCK);
    pre = e2;
    load_start = 1;
    tick();
    load_start = 0;
    chk("load_busy", busy, 1);
    chk("load_byte_ready", byte_ready, 1);
    for (int i = 0; i < 8; i++) begin
      send_byte(8'hFF);
      chk($sformatf("load_busy_b%0d", i), busy, 1);
      chk($sformatf("load_map_hold_b%0d", i), map_bits, pre);
      chk($sformatf("load_done_b%0d", i), load_done, i == 7);
      if (i == 3)
        for (int s = 0; s < 3; s++) begin
          tick();
          chk("stall_busy", busy, 1);
          chk("stall_load_done", load_done, 0);
        end
    end
    chk("commit_byte_ready", byte_ready, 0);
    tick();
    chk("commit_map", map_bits, LOCK ? 64'h007E7E7E7E7E7E00 : 64'hFFFF_FFFF_FFFF_FFFF);
    chk("post_commit_done", load_done, 0);
    chk("post_commit_busy", busy, 0);
    tick();
    chk("single_done_pulse", load_done, 0);
    load_start = 1;
    tick();
    load_start = 0;
    for (int i = 0; i < 5; i++) send_byte(8'hAA);
    load_start = 1;
    byte_valid = 1;
    byte_data = 8'hAA;
    tick();
    load_start = 0;
    byte_valid = 0;
    for (int i = 0; i < 3; i++) send_byte(8'h00);
    chk("restart_no_early_done", load_done, 0);
    chk("restart_still_busy", busy, 1);
    for (int i = 0; i < 5; i++) send_byte(8'h00);
    chk("restart_done", load_done, 1);
    tick();
    chk("restart_map", map_bits, 64'd0);
    load_start = 1;
    tick();
    load_start = 0;
    for (int i = 0; i < 4; i++) send_byte(8'h55);
    reset = 1;
    byte_valid = 1;
    tick();
    reset = 0;
    byte_valid = 0;
    #1;
    chk("midreset_map", map_bits, RMAP);
    chk("midreset_busy", busy, 0);
    chk("midreset_done", load_done, 0);
    tick();
    chk("midreset_idle", edit_ready, 1);
    chk("midreset_no_done", load_done, 0);
    reset = 1;
    tick();
    reset = 0;
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom % 500) == 0;
      load_start = ($urandom % 16) == 0;
      byte_valid = ($urandom % 4) != 0;
      byte_data = 8'($urandom);
      edit_valid = ($urandom % 3) == 0;
      edit_row = 3'($urandom);
      edit_col = 3'($urandom);
      edit_open = 1'($urandom);
      rd_row = ($urandom % 4) == 0 ? 8'($urandom) : 8'($urandom_range(0, 7));
      rd_col = ($urandom % 4) == 0 ? 8'($urandom) : 8'($urandom_range(0, 7));
      tick();
      chk("rnd_map", map_bits, mflat());
      chk("rnd_rd_open", rd_open, m_rd);
      chk("rnd_busy", busy, !reset && (m_loading || m_commit));
      chk("rnd_byte_ready", byte_ready, !reset && m_loading);
      chk("rnd_edit_ready", edit_ready, !reset && !m_loading && !m_commit);
      chk("rnd_load_done", load_done, !reset && m_commit);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
